// File: rtl/l2_response_dispatcher.sv
// L2 outbound dispatcher: steers Channel D beats into per-master FIFOs and
// multicasts Channel B probes until every targeted master has accepted.

module l2_disp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic         full_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PW'(1);
      if (pop_i)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
endmodule

module l2_response_dispatcher #(
  parameter int NUM_MASTERS = 4,
  parameter int FIFO_DEPTH  = 2,
  parameter int DATA_W      = 64,
  parameter int SRC_W       = 4,
  parameter int ADDR_W      = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              d_in_valid,
  output logic                              d_in_ready,
  input  logic [$clog2(NUM_MASTERS)-1:0]    d_in_master_id,
  input  logic [2:0]                        d_in_opcode,
  input  logic [1:0]                        d_in_param,
  input  logic [SRC_W-1:0]                  d_in_source,
  input  logic [DATA_W-1:0]                 d_in_data,
  input  logic                              d_in_last,
  output logic [NUM_MASTERS-1:0]            d_valid_o,
  input  logic [NUM_MASTERS-1:0]            d_ready_i,
  output logic [3*NUM_MASTERS-1:0]          d_opcode_o,
  output logic [2*NUM_MASTERS-1:0]          d_param_o,
  output logic [SRC_W*NUM_MASTERS-1:0]      d_source_o,
  output logic [DATA_W*NUM_MASTERS-1:0]     d_data_o,
  output logic [NUM_MASTERS-1:0]            d_last_o,
  input  logic                              b_in_valid,
  output logic                              b_in_ready,
  input  logic [NUM_MASTERS-1:0]            b_in_mask,
  input  logic [1:0]                        b_in_param,
  input  logic [ADDR_W-1:0]                 b_in_address,
  output logic [NUM_MASTERS-1:0]            b_valid_o,
  input  logic [NUM_MASTERS-1:0]            b_ready_i,
  output logic [1:0]                        b_param_o,
  output logic [ADDR_W-1:0]                 b_address_o,
  output logic                              disp_busy,
  output logic                              proto_err
);
  localparam int IDW = $clog2(NUM_MASTERS);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        param;
    logic [SRC_W-1:0]  source;
    logic [DATA_W-1:0] data;
    logic              last;
  } d_beat_t;
  localparam int BW = $bits(d_beat_t);

  typedef enum logic {B_IDLE, B_ISSUE} b_state_t;

  // ---------------- D path ----------------
  logic                   lock_q, perr_q;
  logic [IDW-1:0]         lock_id_q, tgt;
  logic                   d_push;
  logic [NUM_MASTERS-1:0] push, pop, full, nonempty;
  d_beat_t                in_beat;

  assign tgt        = lock_q ? lock_id_q : d_in_master_id;
  assign d_in_ready = rst_n && !full[tgt];
  assign d_push     = d_in_valid && d_in_ready;
  assign in_beat    = {d_in_opcode, d_in_param, d_in_source, d_in_data, d_in_last};

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
    d_beat_t hb;
    assign push[g] = d_push && (tgt == IDW'(g));
    assign pop[g]  = nonempty[g] && d_ready_i[g];

    l2_disp_fifo #(.DEPTH(FIFO_DEPTH), .W(BW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .wdata_i (in_beat),
      .head_o  (hb),
      .valid_o (nonempty[g]),
      .full_o  (full[g])
    );

    assign d_opcode_o[3*g +: 3]         = hb.opcode;
    assign d_param_o[2*g +: 2]          = hb.param;
    assign d_source_o[SRC_W*g +: SRC_W] = hb.source;
    assign d_data_o[DATA_W*g +: DATA_W] = hb.data;
    assign d_last_o[g]                  = hb.last;
  end

  assign d_valid_o = nonempty;

  // A multi-beat message pins the target until its last beat is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      if (d_in_valid && lock_q && (d_in_master_id != lock_id_q)) perr_q <= 1'b1;
      if (d_push) begin
        lock_q    <= !d_in_last;
        lock_id_q <= tgt;
      end
    end
  end

  assign proto_err = perr_q;

  // ---------------- B path ----------------
  b_state_t               bst_q;
  logic [NUM_MASTERS-1:0] pend_q, pend_d;
  logic [1:0]             bparam_q;
  logic [ADDR_W-1:0]      baddr_q;

  assign pend_d = pend_q & ~b_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bst_q    <= B_IDLE;
      pend_q   <= '0;
      bparam_q <= '0;
      baddr_q  <= '0;
    end else begin
      case (bst_q)
        B_IDLE: begin
          // an empty mask is accepted and dropped
          if (b_in_valid && (b_in_mask != '0)) begin
            pend_q   <= b_in_mask;
            bparam_q <= b_in_param;
            baddr_q  <= b_in_address;
            bst_q    <= B_ISSUE;
          end
        end
        B_ISSUE: begin
          pend_q <= pend_d;
          if (pend_d == '0) bst_q <= B_IDLE;
        end
      endcase
    end
  end

  assign b_in_ready  = rst_n && (bst_q == B_IDLE);
  assign b_valid_o   = pend_q;
  assign b_param_o   = bparam_q;
  assign b_address_o = baddr_q;
  assign disp_busy   = (|nonempty) || (bst_q == B_ISSUE);
endmodule
